// File: rtl/scratchpad_arbiter_if.sv
// Bus bundle between the two scratchpad requesters, the arbiter and the RAM.
// slave = arbiter view, master = requester/RAM environment view.
interface scratchpad_arbiter_if #(
    parameter int DATA_W      = 64,
    parameter int DEPTH_WORDS = 32
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0]                 req_write;
    logic [1:0]                 req_lock;
    logic [1:0][ADDR_W:0]       req_addr;
    logic [1:0][DATA_W-1:0]     req_wdata;
    logic [1:0][DATA_W/8-1:0]   req_wmask;
    logic [1:0]                 rsp_valid;
    logic [1:0]                 rsp_ready;
    logic [1:0][DATA_W-1:0]     rsp_rdata;
    logic [1:0]                 rsp_err;
    logic                       ram_req;
    logic                       ram_write;
    logic [ADDR_W-1:0]          ram_addr;
    logic [DATA_W-1:0]          ram_wdata;
    logic [DATA_W-1:0]          ram_wmask;
    logic [DATA_W-1:0]          ram_rdata;

    modport slave (
        input  req_valid, req_write, req_lock, req_addr, req_wdata, req_wmask,
        input  rsp_ready, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ram_req, ram_write, ram_addr, ram_wdata, ram_wmask
    );

    modport master (
        output req_valid, req_write, req_lock, req_addr, req_wdata, req_wmask,
        output rsp_ready, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ram_req, ram_write, ram_addr, ram_wdata, ram_wmask
    );
endinterface

// File: rtl/scratchpad_arbiter.sv
// Two-requester round-robin arbiter with lock in front of a single-port,
// 1-cycle-latency scratchpad RAM; one response register per requester.
module scratchpad_arbiter #(
    parameter int DATA_W      = 64,
    parameter int DEPTH_WORDS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    scratchpad_arbiter_if.slave  bus
);
    localparam int              ADDR_W  = $clog2(DEPTH_WORDS);
    localparam int              BYTES   = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH_WORDS);

    logic [1:0]             r_pend;
    logic [1:0]             r_wr;
    logic [1:0]             r_err;
    logic [1:0]             r_rsp_valid;
    logic [1:0]             r_rsp_err;
    logic [1:0][DATA_W-1:0] r_rsp_rdata;
    logic                   r_last;
    logic                   r_lock_vld;
    logic                   r_lock_id;

    logic [1:0]             w_elig;
    logic [1:0]             w_inrange;
    logic [1:0]             w_grant;
    logic                   w_gid;
    logic [DATA_W-1:0]      w_bmask;

    // pend blocks back-to-back grants, so the response slot is never overwritten
    always_comb begin
        w_elig    = '0;
        w_inrange = '0;
        for (int i = 0; i < 2; i++) begin
            w_inrange[i] = bus.req_addr[i] < DEPTH_L;
            w_elig[i]    = bus.req_valid[i] && !r_pend[i] &&
                           (!r_rsp_valid[i] || bus.rsp_ready[i]) &&
                           (!r_lock_vld || (r_lock_id == 1'(i)));
        end
    end

    always_comb begin
        w_grant    = '0;
        w_grant[0] = w_elig[0] && (!w_elig[1] || r_last);
        w_grant[1] = w_elig[1] && (!w_elig[0] || !r_last);
        w_gid      = w_grant[1];
    end

    always_comb begin
        w_bmask = '0;
        for (int b = 0; b < BYTES; b++)
            w_bmask[b*8 +: 8] = {8{bus.req_wmask[w_gid][b]}};
    end

    assign bus.req_ready = w_grant;
    assign bus.ram_req   = |w_grant;
    assign bus.ram_write = (|w_grant) && bus.req_write[w_gid] && w_inrange[w_gid];
    assign bus.ram_addr  = bus.req_addr[w_gid][ADDR_W-1:0];
    assign bus.ram_wdata = bus.req_wdata[w_gid];
    assign bus.ram_wmask = w_bmask;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= '0;
            r_wr        <= '0;
            r_err       <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= '0;
            r_rsp_rdata <= '0;
            r_last      <= 1'b1;
            r_lock_vld  <= 1'b0;
            r_lock_id   <= 1'b0;
        end else begin
            if (|w_grant)
                r_last <= w_gid;
            if ((|w_grant) && bus.req_lock[w_gid]) begin
                r_lock_vld <= 1'b1;
                r_lock_id  <= w_gid;
            end else if (r_lock_vld && !bus.req_lock[r_lock_id]) begin
                r_lock_vld <= 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                r_pend[i] <= w_grant[i];
                if (w_grant[i]) begin
                    r_wr[i]  <= bus.req_write[i];
                    r_err[i] <= !w_inrange[i];
                end
                // ram_rdata is valid exactly in the pend cycle
                if (r_pend[i]) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_err[i]   <= r_err[i];
                    r_rsp_rdata[i] <= (!r_wr[i] && !r_err[i]) ? bus.ram_rdata : '0;
                end else if (r_rsp_valid[i] && bus.rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Directed bench for scratchpad_arbiter with a behavioural 32x64 RAM.
module tb_scratchpad_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    scratchpad_arbiter_if #(.DATA_W(64), .DEPTH_WORDS(32)) bus ();
    scratchpad_arbiter #(.DATA_W(64), .DEPTH_WORDS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [63:0] mem [32];

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = '0;
        bus.ram_rdata = '0;
    end

    always @(posedge clk) begin
        if (bus.ram_req) begin
            if (bus.ram_write)
                mem[bus.ram_addr] <= (mem[bus.ram_addr] & ~bus.ram_wmask) |
                                     (bus.ram_wdata & bus.ram_wmask);
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input bit v, input bit w, input bit l,
                         input logic [5:0] a, input logic [63:0] d, input logic [7:0] m);
        bus.req_valid[i] = v;
        bus.req_write[i] = w;
        bus.req_lock[i]  = l;
        bus.req_addr[i]  = a;
        bus.req_wdata[i] = d;
        bus.req_wmask[i] = m;
    endtask

    // single access by requester i alone; returns response fields and grant-cycle ram_write
    task automatic access(input int i, input bit w, input logic [5:0] a, input logic [63:0] d,
                          input logic [7:0] m, output logic [63:0] rd, output logic er,
                          output logic rw);
        int n = 0;
        drive(i, 1'b1, w, 1'b0, a, d, m);
        #1;
        while (!bus.req_ready[i] && n < 8) begin
            @(negedge clk); #1; n++;
        end
        chk("grant_timeout", 64'(n < 8), 64'd1);
        chk("ram_req_on_grant", 64'(bus.ram_req), 64'd1);
        rw = bus.ram_write;
        @(negedge clk);
        bus.req_valid[i] = 1'b0;
        #1;
        chk("rsp_not_early", 64'(bus.rsp_valid[i]), 64'd0);
        @(negedge clk); #1;
        chk("rsp_latency", 64'(bus.rsp_valid[i]), 64'd1);
        rd = bus.rsp_rdata[i];
        er = bus.rsp_err[i];
        @(negedge clk);
    endtask

    logic [63:0] rd;
    logic        er, rw;
    int          nrsp;
    logic [1:0]  exp_lock [9] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01};

    initial begin
        bus.req_valid = '0; bus.req_write = '0; bus.req_lock = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_wmask = '0;
        bus.rsp_ready = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_rsp_rdata0", bus.rsp_rdata[0], 64'd0);
        chk("rst_ram_req", 64'(bus.ram_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        access(0, 1'b1, 6'd3, 64'h1122334455667788, 8'hFF, rd, er, rw);
        chk("wr3_ram_write", 64'(rw), 64'd1);
        chk("wr3_err", 64'(er), 64'd0);
        chk("wr3_rdata_zero", rd, 64'd0);
        access(0, 1'b0, 6'd3, 64'd0, 8'h00, rd, er, rw);
        chk("rd3_data", rd, 64'h1122334455667788);
        chk("rd3_err", 64'(er), 64'd0);

        access(0, 1'b1, 6'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, rd, er, rw);
        access(0, 1'b0, 6'd3, 64'd0, 8'h00, rd, er, rw);
        chk("partial_wr_data", rd, 64'h11223344AAAAAAAA);

        access(1, 1'b1, 6'd5, 64'hCAFEF00D12345678, 8'hFF, rd, er, rw);
        access(0, 1'b0, 6'd5, 64'd0, 8'h00, rd, er, rw);
        chk("req1_wr_rd5", rd, 64'hCAFEF00D12345678);

        access(0, 1'b0, 6'd32, 64'd0, 8'h00, rd, er, rw);
        chk("oor_rd_err", 64'(er), 64'd1);
        chk("oor_rd_rdata", rd, 64'd0);
        access(0, 1'b1, 6'd40, 64'hDEADBEEFDEADBEEF, 8'hFF, rd, er, rw);
        chk("oor_wr_ram_write", 64'(rw), 64'd0);
        chk("oor_wr_err", 64'(er), 64'd1);
        access(0, 1'b0, 6'd8, 64'd0, 8'h00, rd, er, rw);
        chk("oor_wr_no_alias", rd, 64'd0);

        // both requesters streaming reads after a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 6'd3, 64'd0, 8'h00);
        drive(1, 1'b1, 1'b0, 1'b0, 6'd5, 64'd0, 8'h00);
        nrsp = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) begin
                bus.req_valid = 2'b00;
            end
            #1;
            if (c < 8) begin
                chk($sformatf("rr_grant_c%0d", c), 64'(bus.req_ready),
                    (c % 2 == 0) ? 64'd1 : 64'd2);
                chk($sformatf("rr_ram_req_c%0d", c), 64'(bus.ram_req), 64'd1);
            end
            if (c == 2) chk("rr_rdata0", bus.rsp_rdata[0], 64'h11223344AAAAAAAA);
            if (c == 3) chk("rr_rdata1", bus.rsp_rdata[1], 64'hCAFEF00D12345678);
            if (c >= 1) nrsp += int'(bus.rsp_valid[0]) + int'(bus.rsp_valid[1]);
            @(negedge clk);
        end
        chk("rr_resp_count", 64'(nrsp), 64'd8);

        // requester 1 holds the lock across four reads
        for (int c = 0; c < 9; c++) begin
            if (c == 0) drive(1, 1'b1, 1'b0, 1'b1, 6'd5, 64'd0, 8'h00);
            if (c == 1) drive(0, 1'b1, 1'b0, 1'b0, 6'd3, 64'd0, 8'h00);
            if (c == 7) drive(1, 1'b0, 1'b0, 1'b0, 6'd5, 64'd0, 8'h00);
            #1;
            chk($sformatf("lock_grant_c%0d", c), 64'(bus.req_ready), 64'(exp_lock[c]));
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        repeat (3) @(negedge clk);

        // response stall on requester 0, then reset in the middle of it
        bus.rsp_ready = 2'b10;
        drive(0, 1'b1, 1'b0, 1'b0, 6'd3, 64'd0, 8'h00);
        #1;
        chk("stall_first_grant", 64'(bus.req_ready), 64'd1);
        @(negedge clk); @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall_no_grant_c%0d", c), 64'(bus.req_ready), 64'd0);
            chk($sformatf("stall_valid_c%0d", c), 64'(bus.rsp_valid[0]), 64'd1);
            chk($sformatf("stall_rdata_c%0d", c), bus.rsp_rdata[0], 64'h11223344AAAAAAAA);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 2'b11;
        drive(0, 1'b1, 1'b0, 1'b0, 6'd3, 64'd0, 8'h00);
        drive(1, 1'b1, 1'b0, 1'b0, 6'd5, 64'd0, 8'h00);
        #1;
        chk("postrst_tie", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/scratchpad_arbiter.md
Name: scratchpad_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency scratchpad RAM (64-bit words, bit write mask) between two requesters.
- Requester 0 is the host TL-UL adapter path; requester 1 is the LLKI key-load engine.
- Arbitration is round-robin, with an optional per-requester lock for atomic bursts.
- Each requester has a one-entry response register; out-of-range addresses are errored without touching the RAM.

Parameters:
- DATA_W, 64, RAM word width in bits; must be a multiple of 8.
- DEPTH_WORDS, 32, number of RAM words.
- ADDR_W, $clog2(DEPTH_WORDS), width of each requester's word address; local, derived.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  2  request valid; bit i belongs to requester i
- req_ready  output  2  request accepted (grant) this cycle
- req_write  input  2  1 = write, 0 = read
- req_lock  input  2  hold exclusive access while high (see Behaviour)
- req_addr  input  2*ADDR_W+2  word address per requester, ADDR_W+1 bits each; the MSB is used for the range check
- req_wdata  input  2*DATA_W  write data
- req_wmask  input  2*DATA_W/8  byte enables
- rsp_valid  output  2  response valid
- rsp_ready  input  2  response consumed
- rsp_rdata  output  2*DATA_W  read data; 0 for writes and errors
- rsp_err  output  2  address out of range
- ram_req  output  1  RAM select
- ram_write  output  1  RAM write enable
- ram_addr  output  ADDR_W  RAM word address
- ram_wdata  output  DATA_W  RAM write data
- ram_wmask  output  DATA_W  bit mask; each byte-enable bit is replicated x8
- ram_rdata  input  DATA_W  RAM read data, valid the cycle after ram_req

Behaviour:
- Reset values:
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - pend=00 (per-requester "granted last cycle" flags).
  - last_grant=1, so requester 0 wins the first tie.
  - lock_owner=none.
- Eligibility of requester i in cycle t:
  - req_valid[i]=1 and pend[i]=0, and
  - (rsp_valid[i]=0 or rsp_ready[i]=1), and
  - lock_owner is none or i.
  - Consequence: each requester sustains at most one access every 2 cycles; two requesters interleaved reach 100% RAM utilisation.
- Grant (combinational):
  - Exactly one requester is eligible: grant it.
  - Both are eligible: grant the one that is not last_grant.
  - req_ready = grant.
  - last_grant updates only on a grant.
- Lock:
  - If granted requester i has req_lock[i]=1, lock_owner<=i at the clock edge.
  - lock_owner clears on the first cycle where req_lock[owner]=0 (registered).
  - While locked, the other requester is never granted, even if it is valid.
- RAM drive:
  - ram_req = |grant. ram_addr, ram_wdata and ram_wmask come from the granted requester.
  - ram_write = granted write AND in range (addr < DEPTH_WORDS).
  - Out-of-range read: ram_req still asserts (harmless read); the result is discarded.
  - No grant: ram_req=0, ram_write=0, other RAM outputs don't-care.
- Response path:
  - On grant of i: pend[i]<=1, and write flag and err flag are captured.
  - The next cycle (pend[i]=1): rsp_valid[i]<=1, rsp_err[i]<=err flag.
  - rsp_rdata[i] <= (read AND not err) ? ram_rdata : 0.
  - Write latency grant→rsp_valid = 2 edges; read data is aligned the same way.
  - rsp_valid[i] clears on rsp_valid&rsp_ready unless pend[i] reloads it in the same cycle. Eligibility rules guarantee no overwrite.
  - Response data is stable while rsp_valid=1 and rsp_ready=0.
- Simultaneous events: a grant to requester 1 and a response load for requester 0 in the same cycle are independent and both take effect.
- Reset mid-operation clears pend, responses, and lock state immediately. In-flight accesses are dropped; any RAM write already issued stays written.

Test Plan:
- Requester 0 writes addr 3 with data 0x1122334455667788, wmask 0xFF, then reads addr 3 → rsp_valid 2 cycles after grant, rsp_rdata=0x1122334455667788, rsp_err=0.
- Partial write with wmask 0x0F and data 0xAAAAAAAAAAAAAAAA over 0x1122334455667788, then read → 0x11223344AAAAAAAA.
- Both requesters continuously valid with rsp_ready=1 → grants alternate 0,1,0,1 (requester 0 first after reset), ram_req=1 every cycle, 8 responses in 9 cycles.
- Requester 1 asserts req_lock for 4 reads while requester 0 is valid → requester 0 gets no grant until the cycle after lock drops, then is granted next.
- Requester 0 reads addr 32 (DEPTH_WORDS=32) → rsp_err=1, rsp_rdata=0; a write to addr 40 leaves ram_write=0 and RAM contents unchanged.
- rsp_ready[0] held 0 for 5 cycles with req_valid[0]=1 → no further grant to 0, rsp_rdata stable; assert rst mid-stall → all rsp_valid=0 and first post-reset tie goes to requester 0.
